spi_master_driver: RTL and testbench

- Initiator side of the SPI-to-RAM link. Converts a parallel 10-bit command (opcode din[9:8] plus address or data din[7:0]) into one SPI frame on SS_n/MOSI.
- For read-data commands (din[9:8]=2'b11) it also captures the 8-bit response from MISO.
- The serial clock is the system clock `clk`; there is no divided SCLK. Used as the stimulus driver and the reference master in the SPI-slave/RAM wrapper environment.

---
 rtl/spi_master_driver.sv | 117 +++++++++++
 tb/tb_spi_master_driver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/spi_master_driver.sv
// spi_master_driver: SPI initiator that serialises a 10-bit command on SS_n/MOSI and captures an 8-bit read response from MISO.
module spi_master_driver #(
  parameter int RD_WAIT    = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);
  typedef enum logic [2:0] {IDLE, SOF, CMD, SHIFT, TAIL, WAIT, RECV, GAP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  sr_q, sr_d;
  logic        is_rd_q, is_rd_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        ss_n_q, ss_n_d, mosi_q, mosi_d, busy_q, busy_d;
  logic        done_q, done_d, rd_valid_q, rd_valid_d;
  logic        last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      is_rd_q    <= 1'b0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      is_rd_q    <= is_rd_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    sr_d       = sr_q;
    is_rd_d    = is_rd_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    last       = cnt_q == 4'd1;
    case (state_q)
      SOF: state_d = CMD;
      CMD: begin
        state_d = SHIFT;
        cnt_d   = 4'd10;
      end
      SHIFT: begin
        sr_d = {sr_q[8:0], 1'b0};
        if (last) begin
          state_d = is_rd_q ? WAIT : TAIL;
          cnt_d   = 4'(RD_WAIT);
        end
      end
      TAIL: begin
        state_d = GAP;
        cnt_d   = 4'(GAP_CYCLES);
        done_d  = 1'b1;
      end
      WAIT: if (last) begin
        state_d = RECV;
        cnt_d   = 4'd8;
      end
      RECV: begin
        rx_d = {rx_q[5:0], MISO};
        if (last) begin
          state_d    = GAP;
          cnt_d      = 4'(GAP_CYCLES);
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = {rx_q, MISO};
        end
      end
      GAP: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The final GAP cycle doubles as IDLE so a held start gives exactly GAP_CYCLES of SS_n high
    if (start && (state_q == IDLE || (state_q == GAP && last))) begin
      state_d = SOF;
      sr_d    = din;
      is_rd_d = &din[9:8];
      cnt_d   = '0;
    end
    ss_n_d = state_d == IDLE || state_d == GAP;
    busy_d = state_d != IDLE;
    mosi_d = (state_d == CMD || state_d == SHIFT) && sr_d[9];
  end
  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_spi_master_driver.sv
// tb_spi_master_driver: directed frames with a scoreboard queue checked by a negedge monitor that also plays the MISO slave.
module tb_spi_master_driver;
  localparam int RD_WAIT = 3;
  localparam int GAP_CYCLES = 1;
  logic clk, rst_n, start, MISO;
  logic [9:0] din;
  logic busy, done, rd_valid, SS_n, MOSI;
  logic [7:0] rd_data;
  int checks = 0, errors = 0;
  typedef struct {int len; logic [10:0] bits; logic rv; logic [7:0] rd;} exp_t;
  exp_t exp_q[$];
  logic [7:0] miso_byte = 8'h00, exp_rd = 8'h00;
  int k = 0, stray = 0;
  logic [10:0] bits = '0;
  spi_master_driver #(.RD_WAIT(RD_WAIT), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  // Monitor: measures each frame, drives MISO during RECV, pops expectations on done
  always @(negedge clk) begin
    if (!rst_n) begin
      k = 0; bits = '0; stray = 0; MISO = 1'bx;
    end else if (!SS_n) begin
      if (k >= 1 && k <= 11) bits = {bits[9:0], MOSI};
      else if (MOSI) stray++;
      MISO = (k >= 12 + RD_WAIT && k < 20 + RD_WAIT) ? miso_byte[19 + RD_WAIT - k] : 1'bx;
      k++;
    end else begin
      MISO = 1'bx;
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame_len", k, e.len);
          chk("mosi_bits", bits, e.bits);
          chk("mosi_idle_zero", stray, 0);
          chk("rd_valid", rd_valid, e.rv);
          chk("rd_data", rd_data, e.rd);
          chk("busy_at_done", busy, 1);
        end
        k = 0; bits = '0; stray = 0;
      end else if (rd_valid) chk("rd_valid_without_done", 1, 0);
    end
  end
  task automatic push(input logic [9:0] d);
    logic rd;
    rd = d[9:8] == 2'b11;
    if (rd) exp_rd = miso_byte;
    exp_q.push_back('{rd ? 20 + RD_WAIT : 13, {d[9], d}, rd, exp_rd});
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask
  task automatic frame(input logic [9:0] d, input logic [7:0] m);
    miso_byte = m;
    push(d);
    din = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    frame(10'h0A5, 8'h00);
    frame(10'h3FF, 8'hC3);
    // start pulsed mid-SHIFT must be ignored
    miso_byte = 8'h00;
    push(10'h1C3);
    din = 10'h1C3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    din = 10'h3FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; din = '0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("no_extra_frame_busy", busy, 0);
    // start held high: back-to-back frames
    push(10'h100);
    din = 10'h100; start = 1'b1;
    @(negedge clk);
    din = 10'h2AA;
    push(10'h2AA);
    begin
      int n;
      for (n = 0; n < 40; n++) begin
        @(negedge clk);
        if (done) break;
      end
      chk("b2b_done_seen", n < 40, 1);
    end
    chk("b2b_gap_busy", busy, 1);
    @(negedge clk);
    chk("b2b_gap_len_ss_n", SS_n, 0);
    chk("b2b_busy_after_gap", busy, 1);
    start = 1'b0;
    wait_idle();
    frame(10'h3A5, 8'h00);
    frame(10'h155, 8'h5A);
    frame(10'h35A, 8'hFF);
    frame(10'h0AA, 8'h00);
    // async reset in the 5th SHIFT cycle
    push(10'h2F0);
    din = 10'h2F0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", SS_n, 1);
    chk("mid_rst_mosi", MOSI, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_data", rd_data, 8'h00);
    exp_q.delete();
    exp_rd = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(10'h15A, 8'h00);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
